ysyx_23060061_exec_ctrl: RTL and testbench
==========================================

YSYX_23060061_EXEC_CTRL -- requirements
Module: ysyx_23060061_exec_ctrl

Interface
REQ-001 SHALL have one parameter: TIMEOUT_CYCLES, default 255, maximum wait cycles for a memory response before error (range 1..65535).
REQ-002 SHALL have ports, one per line, as follows:
  clk  input  1  single clock, all state on rising edge
  rst_n  input  1  asynchronous, active-low reset
  imem_req_valid  output  1  fetch request valid
  imem_req_ready  input  1  fetch request accepted
  imem_rsp_valid  input  1  instruction word available
  ir_we  output  1  latch instruction register (1-cycle pulse)
  dec_reg_write  input  1  decoder RegWrite
  dec_mem_write  input  1  decoder MemWrite (store)
  dec_is_load  input  1  decoded load
  dec_ebreak  input  1  decoder ebreak
  dmem_req_valid  output  1  data request valid
  dmem_wen  output  1  data request is write
  dmem_req_ready  input  1  data request accepted
  dmem_rsp_valid  input  1  data response / write ack
  rf_we  output  1  register-file write enable (1-cycle pulse)
  pc_we  output  1  PC update enable (1-cycle pulse)
  halt  output  1  sticky, ebreak reached
  err  output  1  sticky, memory timeout
  perf_cycle  output  64  cycle counter
  perf_inst  output  64  retired-instruction counter

Function
REQ-003 SHALL implement FSM states FETCH, IWAIT, DECODE, EXEC, MEM, MWAIT, WB, HALT, ERR.
REQ-004 FETCH: imem_req_valid=1; imem_req_valid=1 and imem_req_ready=1 in same cycle -> IWAIT; else stay, valid held high.
REQ-005 IWAIT: imem_rsp_valid=1 -> ir_we=1 that cycle, next DECODE.
REQ-006 DECODE: one cycle, no outputs asserted, next EXEC.
REQ-007 EXEC: dec_ebreak=1 -> HALT; else dec_is_load or dec_mem_write -> MEM; else -> WB; ebreak takes priority.
REQ-008 MEM: dmem_req_valid=1, dmem_wen=dec_mem_write; handshake -> MWAIT; else hold.
REQ-009 MWAIT: dmem_rsp_valid=1 -> WB.
REQ-010 WB: rf_we=dec_reg_write, pc_we=1 for exactly one cycle, next FETCH; store with dec_reg_write=0 gives rf_we=0.
REQ-011 Timeout counter (16 bit): clears on entry to IWAIT/MWAIT, increments each cycle in them; reaching TIMEOUT_CYCLES without response -> ERR.
REQ-012 Response and timeout in same cycle: response wins, no error.
REQ-013 HALT and ERR are terminal until reset; all handshake/enable outputs 0 there; halt=1 in HALT, err=1 in ERR.
REQ-014 Outputs are decoded from current state only (Moore), except dmem_wen (follows dec_mem_write in MEM) and rf_we (follows dec_reg_write in WB).
REQ-015 Zero-wait memory latency: ALU instruction 5 cycles FETCH-to-FETCH; load/store 7 cycles.
REQ-016 Inputs in states that ignore them (e.g. imem_rsp_valid in FETCH) SHALL have no effect.

Reset
REQ-017 rst_n=0 SHALL asynchronously force state FETCH, timeout counter 0, perf counters 0, and all outputs 0 except imem_req_valid.
REQ-018 imem_req_valid SHALL be 0 while rst_n=0 and 1 in the first cycle after release.
REQ-019 Reset asserted mid-instruction (any state, incl. HALT/ERR) SHALL abort it with no rf_we/pc_we pulse.

Configuration
REQ-020 Macro YSYX_23060061_PERF_CNT_EN defined: perf_cycle increments every cycle out of reset except in HALT/ERR; perf_inst increments on each WB cycle; both wrap at 2^64.
REQ-021 Macro undefined: perf_cycle and perf_inst ports remain, tied to 0; no counter flops.

Verification
REQ-022 Bench SHALL cover:
  ALU instr (dec_reg_write=1), ready/rsp immediate -> ir_we cycle 2, rf_we+pc_we cycle 5, imem_req_valid again cycle 6.
  Store (dec_mem_write=1, reg_write=0), dmem_req_ready low 3 cycles -> dmem_req_valid held 4 cycles with dmem_wen=1, rf_we=0, pc_we=1 once.
  dec_ebreak=1 in EXEC -> halt=1 next cycle, pc_we never pulses, state held 100 cycles.
  TIMEOUT_CYCLES=4, imem_rsp_valid never -> err=1 after 4 IWAIT cycles; rsp on 4th cycle -> no error.
  rst_n low mid-MWAIT -> outputs 0 immediately, FETCH after release, perf counters 0.
  PERF_CNT_EN on, 3 ALU instrs zero-wait -> perf_inst=3, perf_cycle=15.

Source files
------------

// File: rtl/ysyx_23060061_exec_ctrl.sv
// Multi-cycle execution control FSM: fetch/decode/execute/memory/writeback sequencing with memory timeout.
// Optional perf counters are enabled by defining YSYX_23060061_PERF_CNT_EN.
module ysyx_23060061_exec_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  output logic        ir_we,
  input  logic        dec_reg_write,
  input  logic        dec_mem_write,
  input  logic        dec_is_load,
  input  logic        dec_ebreak,
  output logic        dmem_req_valid,
  output logic        dmem_wen,
  input  logic        dmem_req_ready,
  input  logic        dmem_rsp_valid,
  output logic        rf_we,
  output logic        pc_we,
  output logic        halt,
  output logic        err,
  output logic [63:0] perf_cycle,
  output logic [63:0] perf_inst
);

  typedef enum logic [3:0] {
    FETCH, IWAIT, DECODE, EXEC, MEM, MWAIT, WB, HALT, ERR
  } state_t;

  state_t      state, nxt;
  logic [15:0] tcnt;
  logic        timeout;

  // Counter sits at 0 outside the wait states, so entering a wait starts from 0.
  assign timeout = (tcnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      tcnt  <= '0;
    end else begin
      state <= nxt;
      if (state == IWAIT || state == MWAIT) tcnt <= tcnt + 16'd1;
      else                                  tcnt <= '0;
    end
  end

  always_comb begin
    nxt            = state;
    imem_req_valid = 1'b0;
    ir_we          = 1'b0;
    dmem_req_valid = 1'b0;
    dmem_wen       = 1'b0;
    rf_we          = 1'b0;
    pc_we          = 1'b0;
    halt           = 1'b0;
    err            = 1'b0;
    unique case (state)
      FETCH: begin
        // Held low while reset is asserted even though the state is FETCH.
        imem_req_valid = rst_n;
        if (imem_req_ready) nxt = IWAIT;
      end
      IWAIT: begin
        if (imem_rsp_valid) begin
          ir_we = 1'b1;
          nxt   = DECODE;
        end else if (timeout) begin
          nxt = ERR;
        end
      end
      DECODE: nxt = EXEC;
      EXEC: begin
        if (dec_ebreak)                        nxt = HALT;
        else if (dec_is_load || dec_mem_write) nxt = MEM;
        else                                   nxt = WB;
      end
      MEM: begin
        dmem_req_valid = 1'b1;
        dmem_wen       = dec_mem_write;
        if (dmem_req_ready) nxt = MWAIT;
      end
      MWAIT: begin
        if (dmem_rsp_valid) nxt = WB;
        else if (timeout)   nxt = ERR;
      end
      WB: begin
        rf_we = dec_reg_write;
        pc_we = 1'b1;
        nxt   = FETCH;
      end
      HALT:    halt = 1'b1;
      ERR:     err  = 1'b1;
      default: nxt  = FETCH;
    endcase
  end

`ifdef YSYX_23060061_PERF_CNT_EN
  logic [63:0] cyc_q, inst_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q  <= '0;
      inst_q <= '0;
    end else begin
      if (state != HALT && state != ERR) cyc_q <= cyc_q + 64'd1;
      if (state == WB)                   inst_q <= inst_q + 64'd1;
    end
  end

  assign perf_cycle = cyc_q;
  assign perf_inst  = inst_q;
`else
  assign perf_cycle = '0;
  assign perf_inst  = '0;
`endif

endmodule

// File: tb/tb_ysyx_23060061_exec_ctrl.sv
// Scoreboard bench: stimulus pushes per-cycle expected outputs, a negedge monitor pops and compares.
module tb_ysyx_23060061_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid, ir_we;
  logic        dec_reg_write, dec_mem_write, dec_is_load, dec_ebreak;
  logic        dmem_req_valid, dmem_wen, dmem_req_ready, dmem_rsp_valid;
  logic        rf_we, pc_we, halt, err;
  logic [63:0] perf_cycle, perf_inst;

  always #5 clk = ~clk;

  ysyx_23060061_exec_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .ir_we(ir_we),
    .dec_reg_write(dec_reg_write), .dec_mem_write(dec_mem_write),
    .dec_is_load(dec_is_load), .dec_ebreak(dec_ebreak),
    .dmem_req_valid(dmem_req_valid), .dmem_wen(dmem_wen),
    .dmem_req_ready(dmem_req_ready), .dmem_rsp_valid(dmem_rsp_valid),
    .rf_we(rf_we), .pc_we(pc_we), .halt(halt), .err(err),
    .perf_cycle(perf_cycle), .perf_inst(perf_inst)
  );

  typedef struct {
    logic [7:0]  o;   // {imem_req_valid, ir_we, dmem_req_valid, dmem_wen, rf_we, pc_we, halt, err}
    bit          cp;
    logic [63:0] pc;
    logic [63:0] pi;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef YSYX_23060061_PERF_CNT_EN
  localparam logic [63:0] PC15 = 64'd15, PI3 = 64'd3;
`else
  localparam logic [63:0] PC15 = 64'd0, PI3 = 64'd0;
`endif

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e   = q.pop_front();
      act = {imem_req_valid, ir_we, dmem_req_valid, dmem_wen, rf_we, pc_we, halt, err};
      n_cmp++;
      if (act !== e.o) begin
        n_bad++;
        $display("FAIL %s: outputs got %b want %b", e.nm, act, e.o);
      end
      if (e.cp) begin
        n_cmp++;
        if (perf_cycle !== e.pc || perf_inst !== e.pi) begin
          n_bad++;
          $display("FAIL %s_perf: got cycle=%0d inst=%0d want cycle=%0d inst=%0d",
                   e.nm, perf_cycle, perf_inst, e.pc, e.pi);
        end
      end
    end
  end

  task automatic cyc(input logic [7:0] o, input string nm, input bit cp = 0,
                     input logic [63:0] pc = 0, input logic [63:0] pi = 0);
    exp_t e;
    e.o = o; e.cp = cp; e.pc = pc; e.pi = pi; e.nm = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic ir, input logic is, input logic rw, input logic mw,
                        input logic ld, input logic eb, input logic dr, input logic ds);
    imem_req_ready = ir; imem_rsp_valid = is; dec_reg_write = rw; dec_mem_write = mw;
    dec_is_load = ld; dec_ebreak = eb; dmem_req_ready = dr; dmem_rsp_valid = ds;
  endtask

  task automatic alu(input string nm, input bit cp = 0,
                     input logic [63:0] pc = 0, input logic [63:0] pi = 0);
    set_in(1, 1, 1, 0, 0, 0, 1, 1);
    cyc(8'b1000_0000, {nm, "_fetch"}, cp, pc, pi);
    cyc(8'b0100_0000, {nm, "_ir"});
    cyc(8'b0000_0000, {nm, "_dec"});
    cyc(8'b0000_0000, {nm, "_exec"});
    cyc(8'b0000_1100, {nm, "_wb"});
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    cyc(8'b0000_0000, "rst0", 1, 0, 0);
    cyc(8'b0000_0000, "rst1", 1, 0, 0);
    rst_n = 1'b1;

    // Three zero-wait ALU instructions: 15 cycles, 3 retired.
    alu("alu1", 1, 0, 0);
    alu("alu2");
    alu("alu3");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(8'b1000_0000, "perf_after3", 1, PC15, PI3);

    // Store with 3 cycles of backpressure; rsp held high to show it is ignored before MWAIT.
    set_in(1, 1, 0, 1, 0, 0, 0, 1);
    cyc(8'b1000_0000, "st_fetch");
    cyc(8'b0100_0000, "st_ir");
    cyc(8'b0000_0000, "st_dec");
    cyc(8'b0000_0000, "st_exec");
    for (int i = 0; i < 3; i++) cyc(8'b0011_0000, "st_mem_wait");
    dmem_req_ready = 1'b1;
    cyc(8'b0011_0000, "st_mem_hs");
    cyc(8'b0000_0000, "st_mwait");
    cyc(8'b0000_0100, "st_wb");

    // Load whose response lands on the 4th MWAIT cycle, same cycle as timeout.
    set_in(1, 1, 1, 0, 1, 0, 1, 0);
    cyc(8'b1000_0000, "ld_fetch");
    cyc(8'b0100_0000, "ld_ir");
    cyc(8'b0000_0000, "ld_dec");
    cyc(8'b0000_0000, "ld_exec");
    cyc(8'b0010_0000, "ld_mem");
    for (int i = 0; i < 3; i++) cyc(8'b0000_0000, "ld_mwait");
    dmem_rsp_valid = 1'b1;
    cyc(8'b0000_0000, "ld_mwait_rsp");
    cyc(8'b0000_1100, "ld_wb");

    // Fetch response on the 4th IWAIT cycle: no error.
    set_in(1, 0, 1, 0, 0, 0, 0, 0);
    cyc(8'b1000_0000, "iw4_fetch");
    for (int i = 0; i < 3; i++) cyc(8'b0000_0000, "iw4_wait");
    imem_rsp_valid = 1'b1;
    cyc(8'b0100_0000, "iw4_ir");
    cyc(8'b0000_0000, "iw4_dec");
    cyc(8'b0000_0000, "iw4_exec");
    cyc(8'b0000_1100, "iw4_wb");

    // ebreak: halt sticks for 100 cycles with every input asserted.
    set_in(1, 1, 1, 0, 0, 1, 1, 1);
    cyc(8'b1000_0000, "eb_fetch");
    cyc(8'b0100_0000, "eb_ir");
    cyc(8'b0000_0000, "eb_dec");
    cyc(8'b0000_0000, "eb_exec");
    dec_mem_write = 1'b1; dec_is_load = 1'b1;
    for (int i = 0; i < 100; i++) cyc(8'b0000_0010, "halt_hold");

    rst_n = 1'b0;
    cyc(8'b0000_0000, "rst_halt", 1, 0, 0);
    rst_n = 1'b1;

    // Fetch timeout: no response for 4 IWAIT cycles.
    set_in(1, 0, 1, 0, 0, 0, 0, 0);
    cyc(8'b1000_0000, "to_fetch", 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(8'b0000_0000, "to_iwait");
    imem_rsp_valid = 1'b1;
    for (int i = 0; i < 3; i++) cyc(8'b0000_0001, "err_hold");

    rst_n = 1'b0;
    cyc(8'b0000_0000, "rst_err");
    rst_n = 1'b1;

    // Reset asserted while waiting in MWAIT.
    set_in(1, 1, 1, 0, 1, 0, 1, 0);
    cyc(8'b1000_0000, "rm_fetch");
    cyc(8'b0100_0000, "rm_ir");
    cyc(8'b0000_0000, "rm_dec");
    cyc(8'b0000_0000, "rm_exec");
    cyc(8'b0010_0000, "rm_mem");
    cyc(8'b0000_0000, "rm_mwait");
    rst_n = 1'b0;
    cyc(8'b0000_0000, "rst_mwait", 1, 0, 0);
    rst_n = 1'b1;
    set_in(0, 1, 1, 0, 1, 0, 1, 1);
    cyc(8'b1000_0000, "post_rst_fetch", 1, 0, 0);
    cyc(8'b1000_0000, "post_rst_hold");
    alu("alu_final");

    @(posedge clk); #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
